// File: rtl/alu_n_pipe.sv
// WIDTH-bit ALU built from 4-bit 74181-function slices with 74182 group lookahead,
// followed by a LAT-stage valid/ready pipeline and a carry flag for multi-precision chaining.
module alu_n_pipe #(
  parameter int WIDTH = 16,
  parameter int LAT   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       sel,
  input  logic             mode,
  input  logic             cin,
  input  logic             use_cf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero,
  output logic             aeqb,
  output logic             ovf,
  output logic             cf
);

  localparam int NS   = WIDTH / 4;       // 74181 slices
  localparam int NG   = (NS + 3) / 4;    // 74182 groups
  localparam int NPAD = NG * 4;          // slice P/G padded to whole groups

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             co;   // raw polarity: 0 = carry out
    logic             z;
    logic             eq;
    logic             v;
  } payload_t;

  localparam payload_t PAY_RST = '{res: '0, co: 1'b1, z: 1'b0, eq: 1'b0, v: 1'b0};

  // One 74182: carries into slices 1..3 of the group and the group carry-out.
  function automatic logic [3:0] cla182(input logic [3:0] p, input logic [3:0] g, input logic c);
    logic [3:0] co;
    co[0] = g[0] | (p[0] & c);
    co[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
    co[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c);
    co[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
          | (&p & c);
    return co;
  endfunction

  logic             cf_q, cf_d;
  logic             ce;
  logic [WIDTH-1:0] x, y, f;
  logic [NPAD-1:0]  sp, sg;
  logic [NS:0]      sc;                  // active-high carry into each slice
  logic             c_msb;
  logic             c_top;
  payload_t         beat;
  logic [LAT-1:0]   valid_q;
  payload_t         stage_q [LAT];
  logic [LAT-1:0]   take;
  logic             accept;

  assign ce = use_cf ? cf_q : cin;

  // x is the 74181 propagate term, y the generate term; x + y + c is the arithmetic result.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    sp = '0;
    sg = '0;
    x  = a | (b & {WIDTH{sel[0]}}) | (~b & {WIDTH{sel[1]}});
    y  = (a & ~b & {WIDTH{sel[2]}}) | (a & b & {WIDTH{sel[3]}});
    for (int s = 0; s < NS; s++) begin
      sp[s] = &x[4*s +: 4];
      sg[s] = y[4*s+3] | (x[4*s+3] & y[4*s+2]) | (x[4*s+3] & x[4*s+2] & y[4*s+1])
            | (x[4*s+3] & x[4*s+2] & x[4*s+1] & y[4*s]);
    end
  end

  // Lookahead within a group; the group carry-out ripples into the next group.
  always_comb begin
    logic [3:0] co;
    co    = '0;
    sc    = '0;
    sc[0] = ~ce;
    for (int s = 0; s < NS; s++) begin
      co      = cla182(sp[4*(s/4) +: 4], sg[4*(s/4) +: 4], sc[4*(s/4)]);
      sc[s+1] = co[s%4];
    end
  end

  always_comb begin
    logic c;
    c     = 1'b0;
    c_msb = 1'b0;
    f     = '0;
    for (int s = 0; s < NS; s++) begin
      c = sc[s];
      for (int i = 0; i < 4; i++) begin
        if (4*s + i == WIDTH - 1) c_msb = c;
        f[4*s+i] = mode ? ~(x[4*s+i] ^ y[4*s+i]) : (x[4*s+i] ^ y[4*s+i] ^ c);
        c        = y[4*s+i] | (x[4*s+i] & c);
      end
    end
  end

  assign c_top = sc[NS];
  assign beat  = '{res: f, co: ~c_top, z: (f == '0), eq: (&f), v: ~mode & (c_msb ^ c_top)};

  // Stage k can load when some stage at or after k is empty, or the tail is draining.
  always_comb begin
    logic full;
    take = '0;
    full = 1'b0;
    for (int k = 0; k < LAT; k++) begin
      full = 1'b1;
      for (int j = k; j < LAT; j++) full = full & valid_q[j];
      take[k] = out_ready | ~full;
    end
  end

  assign in_ready = take[0];
  assign accept   = in_valid & in_ready;
  assign cf_d     = (accept && !mode) ? beat.co : cf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      cf_q    <= 1'b1;
      // NOTE: every stage payload is reset, not just the valid bits, so the outputs show
      // defined idle values straight out of reset regardless of which stage drives them.
      for (int k = 0; k < LAT; k++) stage_q[k] <= PAY_RST;
    end else begin
      // NOTE: non-blocking assignments so every stage samples the pre-edge value of its neighbour.
      cf_q <= cf_d;
      if (take[0]) begin
        valid_q[0] <= in_valid;
        if (in_valid) stage_q[0] <= beat;
      end
      for (int k = 1; k < LAT; k++) begin
        if (take[k]) begin
          valid_q[k] <= valid_q[k-1];
          if (valid_q[k-1]) stage_q[k] <= stage_q[k-1];
        end
      end
    end
  end

  assign out_valid = valid_q[LAT-1];
  assign result    = stage_q[LAT-1].res;
  assign cout      = stage_q[LAT-1].co;
  assign zero      = stage_q[LAT-1].z;
  assign aeqb      = stage_q[LAT-1].eq;
  assign ovf       = stage_q[LAT-1].v;
  assign cf        = cf_q;

endmodule

// File: tb/tb_alu_n_pipe.sv
// Directed and backpressure checks of alu_n_pipe across several WIDTH/LAT instances.
module tb_alu_n_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid  = 1'b0;
  logic        out_ready = 1'b1;
  logic        in_valid3 = 1'b0;
  logic        out_ready3 = 1'b1;
  logic [31:0] a = '0, b = '0;
  logic [3:0]  sel = '0;
  logic        mode = 1'b0, cin = 1'b1, use_cf = 1'b0;

  logic        ir16, ov16, co16, z16, eq16, v16, cf16;
  logic [15:0] r16;
  logic        ir8, ov8, co8, z8, eq8, v8, cf8;
  logic [7:0]  r8;
  logic        ir32, ov32, co32, z32, eq32, v32, cf32;
  logic [31:0] r32;
  logic        ir3, ov3, co3, z3, eq3, v3, cf3;
  logic [15:0] r3;

  alu_n_pipe #(.WIDTH(16), .LAT(1)) u_d16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir16), .a(a[15:0]), .b(b[15:0]),
    .sel(sel), .mode(mode), .cin(cin), .use_cf(use_cf), .out_valid(ov16), .out_ready(out_ready),
    .result(r16), .cout(co16), .zero(z16), .aeqb(eq16), .ovf(v16), .cf(cf16));

  alu_n_pipe #(.WIDTH(8), .LAT(2)) u_d8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir8), .a(a[7:0]), .b(b[7:0]),
    .sel(sel), .mode(mode), .cin(cin), .use_cf(use_cf), .out_valid(ov8), .out_ready(out_ready),
    .result(r8), .cout(co8), .zero(z8), .aeqb(eq8), .ovf(v8), .cf(cf8));

  alu_n_pipe #(.WIDTH(32), .LAT(1)) u_d32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir32), .a(a), .b(b),
    .sel(sel), .mode(mode), .cin(cin), .use_cf(use_cf), .out_valid(ov32), .out_ready(out_ready),
    .result(r32), .cout(co32), .zero(z32), .aeqb(eq32), .ovf(v32), .cf(cf32));

  alu_n_pipe #(.WIDTH(16), .LAT(3)) u_d3 (
    .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(ir3), .a(a[15:0]), .b(b[15:0]),
    .sel(sel), .mode(mode), .cin(cin), .use_cf(use_cf), .out_valid(ov3), .out_ready(out_ready3),
    .result(r3), .cout(co3), .zero(z3), .aeqb(eq3), .ovf(v3), .cf(cf3));

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offer one beat to the shared instances (t3=0) or the LAT=3 instance (t3=1) for one edge.
  task automatic drive(input logic t3, input logic [3:0] s, input logic m, input logic ci,
                       input logic uc, input logic [31:0] av, input logic [31:0] bv);
    sel = s; mode = m; cin = ci; use_cf = uc; a = av; b = bv;
    if (t3) in_valid3 = 1'b1;
    else    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    in_valid3 = 1'b0;
  endtask

  // Datasheet-table reference for a 16-bit 74181 chain; c is the active-high carry in.
  // Returns {result, cout_raw, zero, aeqb, ovf}.
  function automatic logic [19:0] ref16(input logic [3:0] s, input logic m, input logic c,
                                        input logic [15:0] av, input logic [15:0] bv);
    logic [15:0] xo, yo, fl, res;
    logic [16:0] sum;
    logic        v;
    xo = '0; yo = '0; fl = '0;
    case (s)
      4'h0: begin xo = av;        yo = '0;        fl = ~av;        end
      4'h1: begin xo = av | bv;   yo = '0;        fl = ~(av | bv); end
      4'h2: begin xo = av | ~bv;  yo = '0;        fl = ~av & bv;   end
      4'h3: begin xo = 16'hFFFF;  yo = '0;        fl = '0;         end
      4'h4: begin xo = av;        yo = av & ~bv;  fl = ~(av & bv); end
      4'h5: begin xo = av | bv;   yo = av & ~bv;  fl = ~bv;        end
      4'h6: begin xo = av;        yo = ~bv;       fl = av ^ bv;    end
      4'h7: begin xo = av & ~bv;  yo = 16'hFFFF;  fl = av & ~bv;   end
      4'h8: begin xo = av;        yo = av & bv;   fl = ~av | bv;   end
      4'h9: begin xo = av;        yo = bv;        fl = ~(av ^ bv); end
      4'hA: begin xo = av | ~bv;  yo = av & bv;   fl = bv;         end
      4'hB: begin xo = av & bv;   yo = 16'hFFFF;  fl = av & bv;    end
      4'hC: begin xo = av;        yo = av;        fl = 16'hFFFF;   end
      4'hD: begin xo = av | bv;   yo = av;        fl = av | ~bv;   end
      4'hE: begin xo = av | ~bv;  yo = av;        fl = av | bv;    end
      default: begin xo = av;     yo = 16'hFFFF;  fl = av;         end
    endcase
    sum = {1'b0, xo} + {1'b0, yo} + {16'b0, c};
    v   = !m && (xo[15] == yo[15]) && (sum[15] != xo[15]);
    res = m ? fl : sum[15:0];
    return {res, ~sum[16], (res == 16'h0), (&res), v};
  endfunction

  logic [3:0]  rs;
  logic        rm, rci, ruc, ce, mcf, prev_stall;
  logic [15:0] ra, rb;
  logic [19:0] exp_b, obs_b, prev_pay;
  logic [19:0] sb_q [$];
  int          sent, rcvd;

  initial begin
    // Reset state while rst is held
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 64'(ov16), 64'(1'b0));
    check("rst_in_ready",  64'(ir16), 64'(1'b1));
    check("rst_result",    64'(r16),  64'(16'h0));
    check("rst_cout",      64'(co16), 64'(1'b1));
    check("rst_zero",      64'(z16),  64'(1'b0));
    check("rst_aeqb",      64'(eq16), 64'(1'b0));
    check("rst_ovf",       64'(v16),  64'(1'b0));
    check("rst_cf",        64'(cf16), 64'(1'b1));
    rst = 1'b0;
    @(negedge clk);

    // 16-bit add, LAT=1
    drive(1'b0, 4'b1001, 1'b0, 1'b1, 1'b0, 32'h0000_0003, 32'h0000_0005);
    @(negedge clk);
    check("add_valid",  64'(ov16), 64'(1'b1));
    check("add_result", 64'(r16),  64'(16'h0008));
    check("add_cout",   64'(co16), 64'(1'b1));
    check("add_zero",   64'(z16),  64'(1'b0));
    check("add_ovf",    64'(v16),  64'(1'b0));

    drive(1'b0, 4'b1001, 1'b0, 1'b1, 1'b0, 32'h0000_FFFF, 32'h0000_0001);
    @(negedge clk);
    check("wrap_result", 64'(r16),  64'(16'h0000));
    check("wrap_cout",   64'(co16), 64'(1'b0));
    check("wrap_zero",   64'(z16),  64'(1'b1));
    check("wrap_cf",     64'(cf16), 64'(1'b0));
    check("wrap_ovf",    64'(v16),  64'(1'b0));

    drive(1'b0, 4'b1001, 1'b0, 1'b1, 1'b0, 32'h0000_7FFF, 32'h0000_0001);
    @(negedge clk);
    check("sovf_result", 64'(r16),  64'(16'h8000));
    check("sovf_ovf",    64'(v16),  64'(1'b1));
    check("sovf_cout",   64'(co16), 64'(1'b1));
    check("sovf_cf",     64'(cf16), 64'(1'b1));

    // 8-bit chain, LAT=2: second beat takes the first beat's carry with no bubble
    drive(1'b0, 4'b1001, 1'b0, 1'b1, 1'b0, 32'h0000_00FF, 32'h0000_0001);
    drive(1'b0, 4'b1001, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0);
    @(negedge clk);
    check("chain1_valid",  64'(ov8), 64'(1'b1));
    check("chain1_result", 64'(r8),  64'(8'h00));
    check("chain1_cout",   64'(co8), 64'(1'b0));
    @(negedge clk);
    check("chain2_valid",  64'(ov8), 64'(1'b1));
    check("chain2_result", 64'(r8),  64'(8'h01));
    check("chain2_cout",   64'(co8), 64'(1'b1));
    @(negedge clk);
    check("chain_idle",    64'(ov8), 64'(1'b0));

    // 32-bit: set cf to carry, then a logic op must leave it alone
    drive(1'b0, 4'b1001, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001);
    @(negedge clk);
    check("w32_result", 64'(r32),  64'(32'h0));
    check("w32_zero",   64'(z32),  64'(1'b1));
    check("w32_cf",     64'(cf32), 64'(1'b0));
    drive(1'b0, 4'b0110, 1'b1, 1'b1, 1'b0, 32'hF0F0_1234, 32'h0FF0_1234);
    @(negedge clk);
    check("xor_result", 64'(r32),  64'(32'hFF00_0000));
    check("xor_cf",     64'(cf32), 64'(1'b0));
    check("xor_ovf",    64'(v32),  64'(1'b0));
    check("xor_zero",   64'(z32),  64'(1'b0));
    drive(1'b0, 4'b0110, 1'b0, 1'b1, 1'b0, 32'h1234_5678, 32'h1234_5678);
    @(negedge clk);
    check("cmp_result", 64'(r32),  64'(32'hFFFF_FFFF));
    check("cmp_aeqb",   64'(eq32), 64'(1'b1));
    check("cmp_cout",   64'(co32), 64'(1'b1));
    drive(1'b0, 4'b0110, 1'b0, 1'b0, 1'b0, 32'h1234_5678, 32'h1234_5678);
    @(negedge clk);
    check("sub_result", 64'(r32),  64'(32'h0));
    check("sub_zero",   64'(z32),  64'(1'b1));
    check("sub_cout",   64'(co32), 64'(1'b0));
    check("sub_aeqb",   64'(eq32), 64'(1'b0));

    // LAT=3 latency
    out_ready3 = 1'b1;
    drive(1'b1, 4'b1001, 1'b0, 1'b1, 1'b0, 32'h3, 32'h5);
    @(negedge clk);
    check("lat_e0", 64'(ov3), 64'(1'b0));
    @(negedge clk);
    check("lat_e1", 64'(ov3), 64'(1'b0));
    @(negedge clk);
    check("lat_e2_valid",  64'(ov3), 64'(1'b1));
    check("lat_e2_result", 64'(r3),  64'(16'h0008));
    @(negedge clk);
    check("lat_e3", 64'(ov3), 64'(1'b0));

    // Fill LAT=3 under backpressure, then reset with beats in flight
    out_ready3 = 1'b0;
    drive(1'b1, 4'b1001, 1'b0, 1'b1, 1'b0, 32'h0003, 32'h0005);
    drive(1'b1, 4'b1001, 1'b0, 1'b1, 1'b0, 32'hFFFF, 32'h0002);
    drive(1'b1, 4'b1001, 1'b0, 1'b1, 1'b0, 32'hFFFF, 32'h0001);
    @(negedge clk);
    check("full_in_ready", 64'(ir3), 64'(1'b0));
    check("full_valid",    64'(ov3), 64'(1'b1));
    check("full_head",     64'(r3),  64'(16'h0008));
    check("full_cf",       64'(cf3), 64'(1'b0));
    out_ready3 = 1'b1;
    #1;
    check("full_drain_ready", 64'(ir3), 64'(1'b1));
    out_ready3 = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    check("midrst_valid",  64'(ov3), 64'(1'b0));
    check("midrst_cf",     64'(cf3), 64'(1'b1));
    check("midrst_result", 64'(r3),  64'(16'h0));
    check("midrst_cout",   64'(co3), 64'(1'b1));
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("postrst_ready", 64'(ir3), 64'(1'b1));

    // Random stream on LAT=3 with random backpressure against the table model
    mcf        = 1'b1;
    sent       = 0;
    rcvd       = 0;
    prev_stall = 1'b0;
    prev_pay   = '0;
    for (int cyc = 0; cyc < 400 && rcvd < 10; cyc++) begin
      @(negedge clk);
      rs  = 4'($urandom_range(15, 0));
      rm  = 1'($urandom_range(1, 0));
      rci = 1'($urandom_range(1, 0));
      ruc = 1'($urandom_range(1, 0));
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      sel = rs; mode = rm; cin = rci; use_cf = ruc;
      a = {16'h0, ra};
      b = {16'h0, rb};
      in_valid3  = (sent < 10) && ($urandom_range(3, 0) != 0);
      out_ready3 = 1'($urandom_range(1, 0));
      #1;
      obs_b = {r3, co3, z3, eq3, v3};
      check("bp_in_ready", 64'(ir3), 64'(!(sb_q.size() == 3 && !out_ready3)));
      if (prev_stall) check("bp_stable", 64'(obs_b), 64'(prev_pay));
      if (ov3 && out_ready3) begin
        if (sb_q.size() == 0) check("bp_spurious", 64'(ov3), 64'(1'b0));
        else                  check("bp_payload", 64'(obs_b), 64'(sb_q.pop_front()));
        rcvd++;
      end
      prev_stall = ov3 && !out_ready3;
      prev_pay   = obs_b;
      if (in_valid3 && ir3) begin
        ce    = ruc ? mcf : rci;
        exp_b = ref16(rs, rm, ~ce, ra, rb);
        sb_q.push_back(exp_b);
        if (!rm) mcf = exp_b[3];
        sent++;
      end
    end
    in_valid3 = 1'b0;
    check("bp_drained", 64'(rcvd), 64'(10));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
